// File: rtl/laser_window_ctrl.sv
// -----------------------------------------------------------------------------
// laser_window_ctrl
//   Laser gate for the MEMS scan path. Counts synchronised angle-flag pulses
//   since the last zero (mid-scan) flag and drives the laser from a
//   runtime-programmable table of NUM_WIN on/off windows. Includes arming
//   after the first zero pulse, a sticky missing-zero fault, and a restart
//   input that returns the controller to IDLE.
//
//   Optional feature macro: WIN_SHADOW_EN
//     defined   : table writes go to a shadow copy that is transferred to the
//                 active table on each zero edge and on restart, so the
//                 profile only changes at scan boundaries.
//     undefined : table writes update the active table directly.
// -----------------------------------------------------------------------------
module laser_window_ctrl #(
  parameter int CNT_W       = 12,
  parameter int NUM_WIN     = 4,
  parameter int SYNC_STG    = 2,
  parameter int ARM_CNT     = 601,
  parameter int TIMEOUT_CNT = 4000,
  localparam int IDX_W      = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
) (
  input  logic             clk_50,
  input  logic             rst,
  input  logic             signal_angle,
  input  logic             signal_mid,
  input  logic             restart,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [CNT_W-1:0] wr_on,
  input  logic [CNT_W-1:0] wr_off,
  input  logic             wr_vld,
  output logic             laser,
  output logic [CNT_W-1:0] cnt,
  output logic             running,
  output logic             fault
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_ZERO = 3'd1,
    ST_ARM       = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ARM_VAL     = CNT_W'(ARM_CNT);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CNT);

  // Synchroniser chains and edge-detect history
  logic [SYNC_STG-1:0] angle_sync_r;
  logic [SYNC_STG-1:0] mid_sync_r;
  logic                angle_prev_r;
  logic                mid_prev_r;
  logic                angle_edge_s;
  logic                mid_edge_s;

  // Counter and FSM
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    cnt_next_s;
  state_t              state_r;
  state_t              state_next_s;

  // Registered outputs
  logic                laser_r;
  logic                running_r;
  logic                fault_r;
  logic                hit_s;

  // Active window table
  logic                act_vld_r [NUM_WIN];
  logic [CNT_W-1:0]    act_on_r  [NUM_WIN];
  logic [CNT_W-1:0]    act_off_r [NUM_WIN];

  // Bring the asynchronous MEMS flags into clk_50 and keep one cycle of history
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      angle_sync_r <= {SYNC_STG{1'b0}};
      mid_sync_r   <= {SYNC_STG{1'b0}};
      angle_prev_r <= 1'b0;
      mid_prev_r   <= 1'b0;
    end else begin
      angle_sync_r <= {angle_sync_r[SYNC_STG-2:0], signal_angle};
      mid_sync_r   <= {mid_sync_r[SYNC_STG-2:0], signal_mid};
      angle_prev_r <= angle_sync_r[SYNC_STG-1];
      mid_prev_r   <= mid_sync_r[SYNC_STG-1];
    end
  end

  assign angle_edge_s = angle_sync_r[SYNC_STG-1] & ~angle_prev_r;
  assign mid_edge_s   = mid_sync_r[SYNC_STG-1] & ~mid_prev_r;

  // Next count: restart and zero edge reload to 1 (zero beats a coincident angle edge)
  always_comb begin
    cnt_next_s = cnt_r;
    if (restart) begin
      cnt_next_s = CNT_ONE;
    end else if (mid_edge_s) begin
      cnt_next_s = CNT_ONE;
    end else if (angle_edge_s) begin
      if (cnt_r == CNT_MAX) begin
        cnt_next_s = cnt_r;
      end else begin
        cnt_next_s = cnt_r + CNT_ONE;
      end
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Next state: restart forces one IDLE cycle; timeout only watched while armed or running
  always_comb begin
    state_next_s = state_r;
    if (restart) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_next_s = ST_WAIT_ZERO;
        end
        ST_WAIT_ZERO: begin
          if (mid_edge_s) begin
            state_next_s = ST_ARM;
          end else begin
            state_next_s = ST_WAIT_ZERO;
          end
        end
        ST_ARM: begin
          if (cnt_r >= TIMEOUT_VAL) begin
            state_next_s = ST_FAULT;
          end else if (cnt_r == ARM_VAL) begin
            state_next_s = ST_RUN;
          end else begin
            state_next_s = ST_ARM;
          end
        end
        ST_RUN: begin
          if (cnt_r >= TIMEOUT_VAL) begin
            state_next_s = ST_FAULT;
          end else begin
            state_next_s = ST_RUN;
          end
        end
        ST_FAULT: begin
          state_next_s = ST_FAULT;
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end
  end

  // OR of all enabled windows containing the current count; on>=off never matches
  always_comb begin
    hit_s = 1'b0;
    for (int i = 0; i < NUM_WIN; i++) begin
      hit_s = hit_s | (act_vld_r[i] & (act_on_r[i] <= cnt_r) & (cnt_r < act_off_r[i]));
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ONE;
      laser_r   <= 1'b0;
      running_r <= 1'b0;
      fault_r   <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      cnt_r     <= cnt_next_s;
      laser_r   <= (state_next_s == ST_RUN) & hit_s;
      running_r <= (state_next_s == ST_RUN);
      fault_r   <= (state_next_s == ST_FAULT);
    end
  end

`ifdef WIN_SHADOW_EN
  logic                sh_vld_r [NUM_WIN];
  logic [CNT_W-1:0]    sh_on_r  [NUM_WIN];
  logic [CNT_W-1:0]    sh_off_r [NUM_WIN];

  // Host writes land in the shadow table
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_WIN; i++) begin
        sh_vld_r[i] <= 1'b0;
        sh_on_r[i]  <= {CNT_W{1'b0}};
        sh_off_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_WIN; i++) begin
        if (wr_en && (wr_idx == IDX_W'(i))) begin
          sh_vld_r[i] <= wr_vld;
          sh_on_r[i]  <= wr_on;
          sh_off_r[i] <= wr_off;
        end
      end
    end
  end

  // Shadow becomes active only at a scan boundary (zero edge) or on restart
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_WIN; i++) begin
        act_vld_r[i] <= 1'b0;
        act_on_r[i]  <= {CNT_W{1'b0}};
        act_off_r[i] <= {CNT_W{1'b0}};
      end
    end else if (mid_edge_s || restart) begin
      for (int i = 0; i < NUM_WIN; i++) begin
        act_vld_r[i] <= sh_vld_r[i];
        act_on_r[i]  <= sh_on_r[i];
        act_off_r[i] <= sh_off_r[i];
      end
    end
  end
`else
  // Host writes update the active table directly, visible next cycle
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_WIN; i++) begin
        act_vld_r[i] <= 1'b0;
        act_on_r[i]  <= {CNT_W{1'b0}};
        act_off_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_WIN; i++) begin
        if (wr_en && (wr_idx == IDX_W'(i))) begin
          act_vld_r[i] <= wr_vld;
          act_on_r[i]  <= wr_on;
          act_off_r[i] <= wr_off;
        end
      end
    end
  end
`endif

  assign laser   = laser_r;
  assign cnt     = cnt_r;
  assign running = running_r;
  assign fault   = fault_r;

endmodule

// File: tb/tb_laser_window_ctrl.sv
// -----------------------------------------------------------------------------
// tb_laser_window_ctrl
//   Directed bench for laser_window_ctrl. Expected values are hand-derived;
//   the bench tracks the expected count itself as it issues pulses.
//   Expectations that depend on WIN_SHADOW_EN follow the same macro.
// -----------------------------------------------------------------------------
module tb_laser_window_ctrl;

  logic        clk_50 = 1'b0;
  logic        rst;
  logic        signal_angle;
  logic        signal_mid;
  logic        restart;
  logic        wr_en;
  logic [1:0]  wr_idx;
  logic [11:0] wr_on;
  logic [11:0] wr_off;
  logic        wr_vld;
  logic        laser;
  logic [11:0] cnt;
  logic        running;
  logic        fault;

  int n_vec = 0;
  int n_err = 0;
  int exp_cnt = 1;

`ifdef WIN_SHADOW_EN
  localparam logic SHADOW = 1'b1;
`else
  localparam logic SHADOW = 1'b0;
`endif

  laser_window_ctrl dut (
    .clk_50       (clk_50),
    .rst          (rst),
    .signal_angle (signal_angle),
    .signal_mid   (signal_mid),
    .restart      (restart),
    .wr_en        (wr_en),
    .wr_idx       (wr_idx),
    .wr_on        (wr_on),
    .wr_off       (wr_off),
    .wr_vld       (wr_vld),
    .laser        (laser),
    .cnt          (cnt),
    .running      (running),
    .fault        (fault)
  );

  always #10 clk_50 = ~clk_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_50);
  endtask

  task automatic settle();
    tick(4);
  endtask

  task automatic pulse_angle(input int n);
    repeat (n) begin
      signal_angle = 1'b1;
      tick(1);
      signal_angle = 1'b0;
      tick(1);
      exp_cnt++;
    end
  endtask

  task automatic pulse_zero();
    signal_mid = 1'b1;
    tick(1);
    signal_mid = 1'b0;
    tick(1);
    exp_cnt = 1;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    exp_cnt = 1;
  endtask

  task automatic wr(input int idx, input int on, input int off, input logic v);
    wr_idx = 2'(idx);
    wr_on  = 12'(on);
    wr_off = 12'(off);
    wr_vld = v;
    wr_en  = 1'b1;
    tick(1);
    wr_en  = 1'b0;
  endtask

  // Bounded wait for the count to reach a value, one negedge at a time
  task automatic wait_cnt(input string tag, input int v);
    int k;
    k = 0;
    while ((cnt !== 12'(v)) && (k < 20)) begin
      tick(1);
      k++;
    end
    check(tag, 32'(cnt), v);
  endtask

  initial begin
    rst = 1'b1; signal_angle = 1'b0; signal_mid = 1'b0; restart = 1'b0;
    wr_en = 1'b0; wr_idx = 2'd0; wr_on = 12'd0; wr_off = 12'd0; wr_vld = 1'b0;
    tick(2);
    // reset state
    check("rst_laser", 32'(laser), 0);
    check("rst_cnt", 32'(cnt), 1);
    check("rst_running", 32'(running), 0);
    check("rst_fault", 32'(fault), 0);
    rst = 1'b0;
    tick(2);

    // T2: single window 323..879, arm at 601
    wr(0, 323, 879, 1'b1);
    pulse_zero();
    settle();
    check("t2_cnt_after_zero", 32'(cnt), 32'(exp_cnt));
    pulse_angle(599);
    settle();
    check("t2_cnt600", 32'(cnt), 32'(exp_cnt));
    check("t2_armed_not_running", 32'(running), 0);
    check("t2_laser_off_armed", 32'(laser), 0);
    pulse_angle(1);
    wait_cnt("t2_reach601", 601);
    check("t2_laser_same_cycle_601", 32'(laser), 0);
    tick(1);
    check("t2_laser_rise", 32'(laser), 1);
    check("t2_running", 32'(running), 1);
    pulse_angle(277);
    settle();
    check("t2_laser_878", 32'(laser), 1);
    pulse_angle(1);
    wait_cnt("t2_reach879", 879);
    check("t2_laser_same_cycle_879", 32'(laser), 1);
    tick(1);
    check("t2_laser_fall", 32'(laser), 0);

    // T3: coincident zero and angle edges at 1500
    pulse_angle(621);
    settle();
    check("t3_cnt1500", 32'(cnt), 1500);
    signal_angle = 1'b1;
    signal_mid = 1'b1;
    tick(1);
    signal_angle = 1'b0;
    signal_mid = 1'b0;
    tick(1);
    exp_cnt = 1;
    settle();
    check("t3_collision_cnt", 32'(cnt), 1);
    check("t3_still_running", 32'(running), 1);

    // T5: overlapping and degenerate windows
    wr(0, 700, 800, 1'b1);
    wr(1, 750, 900, 1'b1);
    wr(2, 1000, 1000, 1'b1);
    pulse_zero();
    pulse_angle(698);  settle(); check("t5_699", 32'(laser), 0);
    pulse_angle(1);    settle(); check("t5_700", 32'(laser), 1);
    pulse_angle(99);   settle(); check("t5_799", 32'(laser), 1);
    pulse_angle(1);    settle(); check("t5_800", 32'(laser), 1);
    pulse_angle(99);   settle(); check("t5_899", 32'(laser), 1);
    pulse_angle(1);    settle(); check("t5_900", 32'(laser), 0);
    pulse_angle(100);  settle(); check("t5_1000", 32'(laser), 0);
    check("t5_cnt", 32'(cnt), 32'(exp_cnt));
    pulse_angle(1);    settle(); check("t5_1001", 32'(laser), 0);

    // T6: rewrite window end mid-scan
    wr(0, 323, 879, 1'b1);
    wr(1, 0, 0, 1'b0);
    wr(2, 0, 0, 1'b0);
    pulse_zero();
    pulse_angle(649);  settle(); check("t6_650", 32'(laser), 1);
    wr(0, 323, 700, 1'b1);
    pulse_angle(100);  settle(); check("t6_750_cur_scan", 32'(laser), 32'(SHADOW));
    pulse_angle(128);  settle(); check("t6_878_cur_scan", 32'(laser), 32'(SHADOW));
    pulse_angle(1);    settle(); check("t6_879_cur_scan", 32'(laser), 0);
    pulse_zero();
    pulse_angle(749);  settle(); check("t6_750_next_scan", 32'(laser), 0);
    check("t6_cnt", 32'(cnt), 750);

    // T4: timeout in RUN
    pulse_angle(3249);
    settle();
    check("t4_cnt3999", 32'(cnt), 3999);
    check("t4_no_fault_3999", 32'(fault), 0);
    check("t4_running_3999", 32'(running), 1);
    pulse_angle(1);
    settle();
    check("t4_fault", 32'(fault), 1);
    check("t4_laser_off", 32'(laser), 0);
    check("t4_not_running", 32'(running), 0);
    pulse_zero();
    pulse_angle(399);
    settle();
    check("t4_fault_sticky", 32'(fault), 1);
    check("t4_laser_off_after_zero", 32'(laser), 0);
    check("t4_not_running_after_zero", 32'(running), 0);
    do_restart();
    check("t4_restart_fault", 32'(fault), 0);
    check("t4_restart_cnt", 32'(cnt), 1);
    check("t4_restart_running", 32'(running), 0);
    pulse_angle(700);
    settle();
    check("t4_wait_zero_no_run", 32'(running), 0);
    check("t4_wait_zero_laser", 32'(laser), 0);
    pulse_zero();
    pulse_angle(600);
    settle();
    check("t4_rearm_running", 32'(running), 1);
    check("t4_rearm_laser", 32'(laser), 1);

    // T1: asynchronous reset mid-RUN with laser on
    #3;
    rst = 1'b1;
    #1;
    check("t1_async_laser", 32'(laser), 0);
    check("t1_async_cnt", 32'(cnt), 1);
    check("t1_async_fault", 32'(fault), 0);
    check("t1_async_running", 32'(running), 0);
    tick(1);
    rst = 1'b0;
    exp_cnt = 1;
    tick(2);
    pulse_zero();
    pulse_angle(649);
    settle();
    check("t1_running_after_rst", 32'(running), 1);
    check("t1_windows_cleared", 32'(laser), 0);
    check("t1_cnt", 32'(cnt), 32'(exp_cnt));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
